// File: rtl/mmio_console_if.sv
// ---------------------------------------------------------------------------
// mmio_console_if
// Data-memory port bundle between the core (master) and the console
// responder (slave).
//   addr      core -> console  byte address
//   data_i    core -> console  write data
//   data_en   core -> console  access request this cycle
//   write_en  core -> console  1 = write, 0 = read
//   data_o    console -> core  registered read data
//   hit       console -> core  address falls inside the console window
// ---------------------------------------------------------------------------
interface mmio_console_if;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic        data_en;
    logic        write_en;
    logic [31:0] data_o;
    logic        hit;

    modport master (
        output addr,
        output data_i,
        output data_en,
        output write_en,
        input  data_o,
        input  hit
    );

    modport slave (
        input  addr,
        input  data_i,
        input  data_en,
        input  write_en,
        output data_o,
        output hit
    );
endinterface

// File: rtl/mmio_console.sv
// ---------------------------------------------------------------------------
// mmio_console
// Memory-mapped console responder on the data-memory port. Bytes written to
// TXDATA go through a TX FIFO and out an 8N1 UART pin; STATUS and BAUD_DIV
// are readable; the first word written to EXIT is latched and flags done.
//
// Register window (offset addr[3:2]):
//   0x0 TXDATA   W: push data_i[7:0]          R: 0
//   0x4 STATUS   R: {busy,empty,overflow,0,full}   W1C on bit 2
//   0x8 BAUD_DIV R/W [15:0], 0 behaves as 1
//   0xC EXIT     W: first write latches exit_code, sets done   R: exit_code
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low
//   bus        dmem slave port (addr, data_i, data_en, write_en, data_o, hit)
//   uart_tx    serial output, idle high
//   done       sticky exit flag
//   exit_code  word written to EXIT
// ---------------------------------------------------------------------------
module mmio_console #(
    parameter logic [31:0] BASE         = 32'h600d6000,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          CLKS_PER_BIT = 868
) (
    input  logic         clk,
    input  logic         reset,
    mmio_console_if.slave bus,
    output logic         uart_tx,
    output logic         done,
    output logic [31:0]  exit_code
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Register file
    logic [31:0]      r_data_o;
    logic [15:0]      r_baud;
    logic             r_done;
    logic [31:0]      r_exit_code;
    logic             r_overflow;

    // FIFO
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    // Transmitter
    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_bcnt;
    logic [15:0]      r_div_lat;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;

    logic             w_access;
    logic             w_wr;
    logic             w_rd;
    logic [1:0]       w_off;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_busy;
    logic             w_bit_end;
    logic             w_ovf_set;
    logic             w_ovf_clr;
    logic [15:0]      w_baud_eff;
    logic [31:0]      w_rdata;
    logic             w_unused;

    // Byte-lane bits are irrelevant: every register is a full word.
    assign w_unused   = &{1'b0, bus.addr[1:0]};

    assign bus.hit    = (bus.addr[31:4] == BASE[31:4]);
    assign w_access   = bus.data_en && bus.hit;
    assign w_wr       = w_access && bus.write_en;
    assign w_rd       = w_access && !bus.write_en;
    assign w_off      = bus.addr[3:2];

    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != S_IDLE);

    assign w_baud_eff = (r_baud == 16'd0) ? 16'd1 : r_baud;
    assign w_bit_end  = (r_bcnt == (r_div_lat - 16'd1));

    // A byte is taken either from IDLE or straight out of the stop bit, so
    // queued bytes go out back-to-back without idle gaps.
    assign w_pop      = !w_empty &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

    // A push into a full FIFO still succeeds if a pop frees a slot this cycle.
    assign w_push_req = w_wr && (w_off == 2'd0);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;
    assign w_ovf_clr  = w_wr && (w_off == 2'd1) && bus.data_i[2];

    assign bus.data_o = r_data_o;
    assign done       = r_done;
    assign exit_code  = r_exit_code;

    // ------------------------------------------------------------------
    // Register file and read port
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (w_off)
            2'd0:    w_rdata = '0;
            2'd1:    w_rdata = {27'b0, w_busy, w_empty, r_overflow, 1'b0, w_full};
            2'd2:    w_rdata = {16'b0, r_baud};
            default: w_rdata = r_exit_code;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data_o    <= '0;
            r_baud      <= 16'(CLKS_PER_BIT);
            r_done      <= 1'b0;
            r_exit_code <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_rd) begin
                r_data_o <= w_rdata;
            end
            if (w_wr && (w_off == 2'd2)) begin
                r_baud <= bus.data_i[15:0];
            end
            // Only the first EXIT write counts.
            if (w_wr && (w_off == 2'd3) && !r_done) begin
                r_done      <= 1'b1;
                r_exit_code <= bus.data_i;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage and the frame holding register carry no reset: their contents
    // are only consumed once the pointers/FSM say they are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.data_i[7:0];
        end
        if (w_pop) begin
            r_shift <= r_mem[r_rptr];
        end
    end

    // ------------------------------------------------------------------
    // TX FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_idx == 3'd7)) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_next = w_empty ? S_IDLE : S_START;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // TX FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        uart_tx = 1'b1;
        case (r_state)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = r_shift[r_idx];
            default: uart_tx = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Bit timing. The divider is sampled at pop time so BAUD_DIV writes
    // during a frame only apply to the following frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bcnt    <= '0;
            r_idx     <= '0;
            r_div_lat <= 16'd1;
        end else if (w_pop) begin
            r_bcnt    <= '0;
            r_idx     <= '0;
            r_div_lat <= w_baud_eff;
        end else if (r_state != S_IDLE) begin
            if (w_bit_end) begin
                r_bcnt <= '0;
                if (r_state == S_DATA) begin
                    r_idx <= r_idx + 3'd1;
                end
            end else begin
                r_bcnt <= r_bcnt + 16'd1;
            end
        end
    end

endmodule
